// File: rtl/subtractor_serial_if.sv
// Handshake and operand/result bundle for the bit-serial subtractor.
interface subtractor_serial_if #(
  parameter int unsigned size = 4
);
  logic            start;
  logic [size-1:0] a;
  logic [size-1:0] b;
  logic            i_b;
  logic            busy;
  logic            done;
  logic [size-1:0] diff;
  logic            o_b;

  modport master (
    output start, a, b, i_b,
    input  busy, done, diff, o_b
  );

  modport slave (
    input  start, a, b, i_b,
    output busy, done, diff, o_b
  );
endinterface

// File: rtl/subtractor_serial.sv
// Bit-serial unsigned subtractor: diff = a - b - i_b, one bit per clock, LSB first.
// Results update only at completion; done pulses for one cycle.
module subtractor_serial #(
  parameter int unsigned size = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  subtractor_serial_if.slave bus
);
  localparam int unsigned W  = size;
  localparam int unsigned CW = $clog2(size) + 1;

  typedef enum logic {IDLE, RUN} state_e;

  state_e         state_q, state_d;
  logic [W-1:0]   sa_q, sa_d;
  logic [W-1:0]   sb_q, sb_d;
  logic [W-1:0]   sd_q, sd_d;
  logic [W-1:0]   diff_q, diff_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           br_q, br_d;
  logic           ob_q, ob_d;
  logic           busy_q, busy_d;
  logic           done_q, done_d;

  logic           d_c;
  logic           br_next_c;

  // Full-subtractor on the current LSBs
  assign d_c       = sa_q[0] ^ sb_q[0] ^ br_q;
  assign br_next_c = (~sa_q[0] & sb_q[0]) | (~(sa_q[0] ^ sb_q[0]) & br_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      sa_q    <= '0;
      sb_q    <= '0;
      sd_q    <= '0;
      diff_q  <= '0;
      cnt_q   <= '0;
      br_q    <= 1'b0;
      ob_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sa_q    <= sa_d;
      sb_q    <= sb_d;
      sd_q    <= sd_d;
      diff_q  <= diff_d;
      cnt_q   <= cnt_d;
      br_q    <= br_d;
      ob_q    <= ob_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    sa_d    = sa_q;
    sb_d    = sb_q;
    sd_d    = sd_q;
    diff_d  = diff_q;
    cnt_d   = cnt_q;
    br_d    = br_q;
    ob_d    = ob_q;
    busy_d  = busy_q;
    done_d  = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          sa_d    = bus.a;
          sb_d    = bus.b;
          br_d    = bus.i_b;
          cnt_d   = '0;
          busy_d  = 1'b1;
          state_d = RUN;
        end
      end
      RUN: begin
        sd_d  = {d_c, sd_q[W-1:1]};
        sa_d  = sa_q >> 1;
        sb_d  = sb_q >> 1;
        br_d  = br_next_c;
        cnt_d = cnt_q + CW'(1);
        // Last bit: publish the assembled result and the final borrow
        if (cnt_q == CW'(W - 1)) begin
          diff_d  = {d_c, sd_q[W-1:1]};
          ob_d    = br_next_c;
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.diff = diff_q;
  assign bus.o_b  = ob_q;

endmodule

// File: tb/tb_subtractor_serial.sv
// Directed and randomized bench for subtractor_serial at size 4 and size 8.
module tb_subtractor_serial;
  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_err;

  subtractor_serial_if #(.size(4)) bus4 ();
  subtractor_serial_if #(.size(8)) bus8 ();

  subtractor_serial #(.size(4)) dut4 (.clk(clk), .rst_n(rst_n), .bus(bus4));
  subtractor_serial #(.size(8)) dut8 (.clk(clk), .rst_n(rst_n), .bus(bus8));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Launch one size-4 operation; returns edges from accept to done and busy-high samples.
  task automatic op4(input logic [3:0] a, input logic [3:0] b, input logic ib,
                     output int lat, output int bc);
    @(negedge clk);
    bus4.a = a; bus4.b = b; bus4.i_b = ib; bus4.start = 1'b1;
    @(posedge clk); #1;
    bus4.start = 1'b0;
    bus4.a = ~a; bus4.b = ~b; bus4.i_b = ~ib;
    lat = 0; bc = 0;
    while (!bus4.done && lat < 20) begin
      if (bus4.busy) bc++;
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic op8(input logic [7:0] a, input logic [7:0] b, input logic ib, output int lat);
    @(negedge clk);
    bus8.a = a; bus8.b = b; bus8.i_b = ib; bus8.start = 1'b1;
    @(posedge clk); #1;
    bus8.start = 1'b0;
    lat = 0;
    while (!bus8.done && lat < 30) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  initial begin
    int lat, bc, cnt;
    logic [8:0] ref9;
    logic [7:0] ra, rb;
    logic       rib;

    n_cmp = 0; n_err = 0;
    rst_n = 1'b0;
    bus4.start = 1'b0; bus4.a = '0; bus4.b = '0; bus4.i_b = 1'b0;
    bus8.start = 1'b0; bus8.a = '0; bus8.b = '0; bus8.i_b = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", 32'(bus4.busy), 0);
    chk("rst_done", 32'(bus4.done), 0);
    chk("rst_diff", 32'(bus4.diff), 0);
    chk("rst_ob",   32'(bus4.o_b),  0);
    @(negedge clk); rst_n = 1'b1;

    // 5 - 3 - 0
    op4(4'd5, 4'd3, 1'b0, lat, bc);
    chk("t1_lat",  32'(lat), 4);
    chk("t1_busy", 32'(bc), 4);
    chk("t1_diff", 32'(bus4.diff), 2);
    chk("t1_ob",   32'(bus4.o_b), 0);
    chk("t1_busy_in_done", 32'(bus4.busy), 0);
    @(posedge clk); #1;
    chk("t1_done_pulse", 32'(bus4.done), 0);
    chk("t1_diff_hold",  32'(bus4.diff), 2);

    op4(4'd3, 4'd5, 1'b0, lat, bc);
    chk("t2_lat", 32'(lat), 4); chk("t2_diff", 32'(bus4.diff), 14); chk("t2_ob", 32'(bus4.o_b), 1);
    op4(4'd0, 4'd0, 1'b1, lat, bc);
    chk("t3_lat", 32'(lat), 4); chk("t3_diff", 32'(bus4.diff), 15); chk("t3_ob", 32'(bus4.o_b), 1);
    op4(4'd15, 4'd15, 1'b0, lat, bc);
    chk("t4_lat", 32'(lat), 4); chk("t4_diff", 32'(bus4.diff), 0); chk("t4_ob", 32'(bus4.o_b), 0);
    op4(4'd8, 4'd9, 1'b0, lat, bc);
    chk("t5_lat", 32'(lat), 4); chk("t5_diff", 32'(bus4.diff), 15); chk("t5_ob", 32'(bus4.o_b), 1);

    // Start during RUN must be ignored
    @(negedge clk);
    bus4.a = 4'd10; bus4.b = 4'd4; bus4.i_b = 1'b0; bus4.start = 1'b1;
    @(posedge clk); #1;
    bus4.start = 1'b0;
    @(posedge clk); #1;
    chk("ign_partial_diff", 32'(bus4.diff), 15);
    bus4.a = 4'd1; bus4.b = 4'd1; bus4.start = 1'b1;
    @(posedge clk); #1;
    bus4.start = 1'b0;
    lat = 2;
    while (!bus4.done && lat < 20) begin @(posedge clk); #1; lat++; end
    chk("ign_lat",  32'(lat), 4);
    chk("ign_diff", 32'(bus4.diff), 6);
    chk("ign_ob",   32'(bus4.o_b), 0);

    // Back-to-back: start asserted in the done cycle with new operands
    bus4.a = 4'd9; bus4.b = 4'd2; bus4.i_b = 1'b0; bus4.start = 1'b1;
    @(posedge clk); #1;
    bus4.start = 1'b0;
    chk("b2b_busy", 32'(bus4.busy), 1);
    cnt = 1;
    while (!bus4.done && cnt < 20) begin
      chk("b2b_hold", 32'(bus4.diff), 6);
      @(posedge clk); #1;
      cnt++;
    end
    chk("b2b_gap",  32'(cnt), 5);
    chk("b2b_diff", 32'(bus4.diff), 7);
    cnt = 0;
    repeat (10) begin @(posedge clk); #1; if (bus4.done) cnt++; end
    chk("no_extra_done", 32'(cnt), 0);

    // Asynchronous reset mid-RUN
    @(negedge clk);
    bus4.a = 4'd7; bus4.b = 4'd2; bus4.start = 1'b1;
    @(posedge clk); #1;
    bus4.start = 1'b0;
    @(posedge clk); #1;
    chk("pre_rst_busy", 32'(bus4.busy), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_busy", 32'(bus4.busy), 0);
    chk("arst_done", 32'(bus4.done), 0);
    chk("arst_diff", 32'(bus4.diff), 0);
    chk("arst_ob",   32'(bus4.o_b),  0);
    @(negedge clk); rst_n = 1'b1;
    cnt = 0;
    repeat (8) begin @(posedge clk); #1; if (bus4.done) cnt++; end
    chk("arst_no_done", 32'(cnt), 0);
    op4(4'd2, 4'd1, 1'b0, lat, bc);
    chk("post_rst_lat",  32'(lat), 4);
    chk("post_rst_diff", 32'(bus4.diff), 1);
    chk("post_rst_ob",   32'(bus4.o_b), 0);

    // size-8 corners then random sweep against {1'b0,a} - b - i_b
    for (int i = 0; i < 1004; i++) begin
      case (i)
        0:       begin ra = 8'd255; rb = 8'd0;   rib = 1'b0; end
        1:       begin ra = 8'd0;   rb = 8'd255; rib = 1'b1; end
        2:       begin ra = 8'd128; rb = 8'd127; rib = 1'b1; end
        3:       begin ra = 8'd0;   rb = 8'd0;   rib = 1'b0; end
        default: begin ra = 8'($urandom); rb = 8'($urandom); rib = 1'($urandom); end
      endcase
      ref9 = {1'b0, ra} - {1'b0, rb} - {8'd0, rib};
      op8(ra, rb, rib, lat);
      chk("s8_lat",  32'(lat), 8);
      chk("s8_diff", 32'(bus8.diff), 32'(ref9[7:0]));
      chk("s8_ob",   32'(bus8.o_b),  32'(ref9[8]));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/subtractor_serial.md
# subtractor_serial

Bit-serial unsigned subtractor that computes `a - b - i_b` one bit per clock, LSB first, with a start/done handshake. It inverts the operation of the parameterized ripple-carry adder and gives the arithmetic tutorial blocks a sequential, area-lean counterpart. It sits beside that adder so the two can be cross-checked (`a + b` followed by `-b` restores `a`).

## Interface
- `size`, default 4, operand and result width in bits; legal range 2..32.

- `clk` in 1: single clock; all state changes on the rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `start` in 1: request; sampled only in IDLE.
- `a` in `size`: minuend; captured on the accepting edge.
- `b` in `size`: subtrahend; captured on the accepting edge.
- `i_b` in 1: borrow-in; captured on the accepting edge.
- `busy` out 1: high while an operation is in progress (RUN state).
- `done` out 1: one-cycle pulse when `diff`/`o_b` are updated.
- `diff` out `size`: result `(a - b - i_b) mod 2^size`; holds until the next completion.
- `o_b` out 1: borrow-out; equals 1 iff `a < b + i_b` (unsigned).

## Operation
- Internal state: FSM {IDLE, RUN}, shift registers `sa`/`sb` (`size` bits each), result shift register `sd` (`size` bits), borrow flop `br`, and bit counter `cnt` (`$clog2(size)+1` bits).
- IDLE with `start`=1 at an edge (accept):
  - `sa<=a`, `sb<=b`, `br<=i_b`, `cnt<=0`.
  - Go to RUN; `busy<=1`.
- RUN, each edge:
  - Full-subtractor on the LSBs: `d = sa[0]^sb[0]^br`.
  - `br <= (~sa[0]&sb[0]) | (~(sa[0]^sb[0])&br)`.
  - `sd <= {d, sd[size-1:1]}`; `sa`/`sb` shift right; `cnt<=cnt+1`.
- Completion: on the RUN edge where `cnt==size-1`:
  - `diff <= {d, sd[size-1:1]}`, `o_b <=` new borrow, `done<=1`, `busy<=0`.
  - Return to IDLE.
- `done` is cleared on the next edge unconditionally.
- `start` during RUN is ignored: no queueing and no effect on the operation in progress.
- `start` during the `done` cycle is accepted normally because the FSM is already in IDLE, so back-to-back operations are legal.
- `a`, `b`, `i_b` may change freely after the accepting edge.
- `diff`/`o_b` never change except at completion or reset. They do not show partial results during RUN.
- Arithmetic is unsigned modulo `2^size`. A signed view is the caller's concern.

## Timing
- Reset (`rst_n`=0, asynchronous, immediate):
  - FSM=IDLE, `busy`=0, `done`=0, `diff`=0, `o_b`=0.
  - All internal registers are cleared.
  - Release is synchronous to the next edge; the first `start` is honoured on the first edge with `rst_n`=1.
- Latency: accepting edge E0, then RUN edges E1..E`size`. `done` is high for exactly one cycle after E`size`.
- `busy` is high from after E0 through E`size`; it is low in the `done` cycle.
- Throughput: one operation per `size`+1 cycles with back-to-back starts.
- Reset mid-RUN: the operation is aborted, no `done` is produced, and the outputs go to their reset values.

## Test plan
- `size`=4, `a`=5, `b`=3, `i_b`=0, pulse `start` -> `done` exactly 4 edges after the accepting edge; `diff`=2, `o_b`=0; `busy` high for 4 cycles.
- `size`=4 operand set, each run to completion:
  - `a`=3, `b`=5, `i_b`=0 -> `diff`=14, `o_b`=1.
  - `a`=0, `b`=0, `i_b`=1 -> `diff`=15, `o_b`=1.
  - `a`=15, `b`=15, `i_b`=0 -> `diff`=0, `o_b`=0.
  - `a`=8, `b`=9, `i_b`=0 -> `diff`=15, `o_b`=1.
- Start ignored while busy: accept `a`=10, `b`=4; pulse `start` with `a`=1, `b`=1 during cycle 2 of RUN -> a single `done` with `diff`=6, `o_b`=0; no second `done`.
- Back-to-back: hold `start`=1 through the `done` cycle with new operands `a`=9, `b`=2 -> second `done` exactly 5 cycles after the first, `diff`=7; `diff` holds 6 until then.
- Reset mid-operation: assert `rst_n`=0 between edges during RUN -> `busy`, `done`, `diff`, `o_b` go to 0 immediately without waiting for a clock; no `done` follows. The next start with `a`=2, `b`=1 -> `diff`=1.
- `size`=8 random sweep (≥1000 vectors) against the reference model `{o_b, diff} = {1'b0, a} - b - i_b` -> zero mismatches, and latency is always 8.
